// File: rtl/mure_pkg.sv
// -----------------------------------------------------------------------------
// mure_pkg
// Shared widths and types for the MURE trace front-end. This package provides
// the retirement field widths, the default retirement lane count, and the
// retire_entry_t record stored by mure_retire_buffer. The idx_width() helper
// returns the width of an index over n items, never less than one bit.
// -----------------------------------------------------------------------------
package mure_pkg;

    localparam int unsigned NrRetiredInstr = 2;
    localparam int unsigned XLEN           = 64;
    localparam int unsigned ITYPE_LEN      = 3;
    localparam int unsigned CAUSE_LEN      = 5;
    localparam int unsigned TVAL_LEN       = 64;
    localparam int unsigned PRIV_LEN       = 2;

    // One retired instruction, carrying its own copy of the bundle-shared trap
    // fields so that entries from different bundles can coexist in a FIFO.
    typedef struct packed {
        logic                 ilastsize;
        logic [ITYPE_LEN-1:0] itype;
        logic [CAUSE_LEN-1:0] cause;
        logic [TVAL_LEN-1:0]  tval;
        logic [PRIV_LEN-1:0]  priv;
        logic [XLEN-1:0]      iaddr;
    } retire_entry_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mure_lane_compact.sv
// -----------------------------------------------------------------------------
// mure_lane_compact
// Combinational compaction of NR_IN sparse valid lanes into a dense list. The
// list is ordered lowest lane first.
//   valid_i  in   NR_IN          per-lane valid flag
//   sel_o    out  NR_IN x IdxW   source lane index for each dense slot
//                                (0 for unused slots)
//   cnt_o    out  CntW           number of valid lanes (popcount)
// -----------------------------------------------------------------------------
module mure_lane_compact
    import mure_pkg::*;
#(
    parameter  int unsigned NR_IN = NrRetiredInstr,
    localparam int unsigned IdxW  = idx_width(NR_IN),
    localparam int unsigned CntW  = $clog2(NR_IN + 1)
) (
    input  logic [NR_IN-1:0]           valid_i,
    output logic [NR_IN-1:0][IdxW-1:0] sel_o,
    output logic [CntW-1:0]            cnt_o
);

    // pre[i] counts the valid lanes below lane i. It is lane i's dense slot.
    logic [CntW-1:0] pre [NR_IN+1];

    always_comb begin
        // NOTE: every combinational output gets a default before any
        //       conditional assignment, so no path can leave it unassigned
        //       and infer a latch.
        sel_o  = '0;
        pre[0] = '0;
        for (int i = 0; i < NR_IN; i++) begin
            pre[i+1] = pre[i] + CntW'(valid_i[i]);
        end
        for (int k = 0; k < NR_IN; k++) begin
            for (int i = 0; i < NR_IN; i++) begin
                if (valid_i[i] && (pre[i] == CntW'(k))) begin
                    sel_o[k] = IdxW'(i);
                end
            end
        end
        cnt_o = pre[NR_IN];
    end

endmodule

// File: rtl/mure_retire_buffer.sv
// -----------------------------------------------------------------------------
// mure_retire_buffer
// This module sits between the commit stage and the trace encoder. Each cycle
// it accepts up to NR_IN retired instructions on sparse lanes. It compacts
// them in program order into a DEPTH-entry FIFO, and presents up to NR_OUT of
// the oldest entries under a valid/ready handshake.
//
//   clk_i, rst_i        clock; synchronous active-high reset
//   iretire_i           per-lane retire flag (bundle present when any is set)
//   ilastsize_i/itype_i/iaddr_i   per-lane instruction fields
//   cause_i/tval_i/priv_i         bundle-shared trap fields, copied per entry
//   in_ready_o          bundle accepted this cycle if present
//   out_valid_o         output lane j holds entry (rd_ptr + j)
//   out_ready_i         consumer takes every valid output lane
//   iretire_o .. iaddr_o          per-output-lane entry fields (0 if invalid)
//   stall_cnt_o         saturating count of cycles a present bundle was
//                       refused; exists only with MURE_RETIRE_STATS_EN
//
// Build option: define MURE_RETIRE_STATS_EN to add stall_cnt_o.
// -----------------------------------------------------------------------------
module mure_retire_buffer
    import mure_pkg::*;
#(
    parameter int unsigned NR_IN  = NrRetiredInstr,
    parameter int unsigned NR_OUT = 1,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NR_IN-1:0]            iretire_i,
    input  logic [NR_IN-1:0]            ilastsize_i,
    input  logic [NR_IN*ITYPE_LEN-1:0]  itype_i,
    input  logic [NR_IN*XLEN-1:0]       iaddr_i,
    input  logic [CAUSE_LEN-1:0]        cause_i,
    input  logic [TVAL_LEN-1:0]         tval_i,
    input  logic [PRIV_LEN-1:0]         priv_i,
    output logic                        in_ready_o,
    output logic [NR_OUT-1:0]           out_valid_o,
    input  logic                        out_ready_i,
    output logic [NR_OUT-1:0]           iretire_o,
    output logic [NR_OUT-1:0]           ilastsize_o,
    output logic [NR_OUT*ITYPE_LEN-1:0] itype_o,
    output logic [NR_OUT*CAUSE_LEN-1:0] cause_o,
    output logic [NR_OUT*TVAL_LEN-1:0]  tval_o,
    output logic [NR_OUT*PRIV_LEN-1:0]  priv_o,
    output logic [NR_OUT*XLEN-1:0]      iaddr_o
`ifdef MURE_RETIRE_STATS_EN
    ,
    output logic [31:0]                 stall_cnt_o
`endif
);

    localparam int unsigned PtrW   = idx_width(DEPTH);
    localparam int unsigned CntW   = $clog2(DEPTH + 1);
    localparam int unsigned IdxW   = idx_width(NR_IN);
    localparam int unsigned InCntW = $clog2(NR_IN + 1);

    retire_entry_t          mem_q [DEPTH];
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]        count_q, count_d;

    logic [NR_IN-1:0][IdxW-1:0] lane_sel;
    logic [InCntW-1:0]      push_cnt;
    retire_entry_t          new_entry [NR_IN];
    logic                   bundle_present;
    logic                   accept;
    logic [CntW-1:0]        pushed;
    logic [CntW-1:0]        popped;

    mure_lane_compact #(.NR_IN(NR_IN)) u_compact (
        .valid_i (iretire_i),
        .sel_o   (lane_sel),
        .cnt_o   (push_cnt)
    );

    // Readiness uses only the registered count. A pop in the same cycle is
    // ignored, so there is no combinational path from out_ready_i.
    assign in_ready_o     = rst_i | ((CntW'(DEPTH) - count_q) >= CntW'(NR_IN));
    assign bundle_present = |iretire_i;
    assign accept         = bundle_present & in_ready_o & ~rst_i;

    always_comb begin
        pushed = accept ? CntW'(push_cnt) : '0;
        popped = '0;
        if (out_ready_i) begin
            popped = (count_q >= CntW'(NR_OUT)) ? CntW'(NR_OUT) : count_q;
        end
        // Pointers span exactly DEPTH slots, so truncation gives the wrap.
        wr_ptr_d = wr_ptr_q + PtrW'(pushed);
        rd_ptr_d = rd_ptr_q + PtrW'(popped);
        count_d  = count_q + pushed - popped;
    end

    // Dense slot k takes its per-lane fields from source lane lane_sel[k].
    always_comb begin
        for (int k = 0; k < NR_IN; k++) begin
            new_entry[k].ilastsize = ilastsize_i[lane_sel[k]];
            new_entry[k].itype     = itype_i[int'(lane_sel[k])*ITYPE_LEN +: ITYPE_LEN];
            new_entry[k].cause     = cause_i;
            new_entry[k].tval      = tval_i;
            new_entry[k].priv      = priv_i;
            new_entry[k].iaddr     = iaddr_i[int'(lane_sel[k])*XLEN +: XLEN];
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so that
        //       every flop samples pre-edge values regardless of block order.
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            // NOTE: the storage is cleared on reset deliberately. Stale trap
            //       fields must never reappear after a reset, and the array is
            //       small enough to give every entry a reset.
            for (int d = 0; d < DEPTH; d++) begin
                mem_q[d] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int k = 0; k < NR_IN; k++) begin
                if (accept && (InCntW'(k) < push_cnt)) begin
                    mem_q[wr_ptr_q + PtrW'(k)] <= new_entry[k];
                end
            end
        end
    end

    always_comb begin
        out_valid_o = '0;
        iretire_o   = '0;
        ilastsize_o = '0;
        itype_o     = '0;
        cause_o     = '0;
        tval_o      = '0;
        priv_o      = '0;
        iaddr_o     = '0;
        for (int j = 0; j < NR_OUT; j++) begin
            if (!rst_i && (count_q > CntW'(j))) begin
                out_valid_o[j]                       = 1'b1;
                iretire_o[j]                         = 1'b1;
                ilastsize_o[j]                       = mem_q[rd_ptr_q + PtrW'(j)].ilastsize;
                itype_o[j*ITYPE_LEN +: ITYPE_LEN]    = mem_q[rd_ptr_q + PtrW'(j)].itype;
                cause_o[j*CAUSE_LEN +: CAUSE_LEN]    = mem_q[rd_ptr_q + PtrW'(j)].cause;
                tval_o[j*TVAL_LEN +: TVAL_LEN]       = mem_q[rd_ptr_q + PtrW'(j)].tval;
                priv_o[j*PRIV_LEN +: PRIV_LEN]       = mem_q[rd_ptr_q + PtrW'(j)].priv;
                iaddr_o[j*XLEN +: XLEN]              = mem_q[rd_ptr_q + PtrW'(j)].iaddr;
            end
        end
    end

`ifdef MURE_RETIRE_STATS_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (bundle_present && !in_ready_o && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = rst_i ? '0 : stall_cnt_q;
`endif

endmodule
